// File: rtl/phase_frame_sched.sv
// Serialises one frame from each phase source and then the tag source into a single
// AXI-Stream, enforcing frame length and reporting per-source framing errors.
module phase_frame_sched #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BEAT_SIZE    = 8,
  parameter int unsigned TAG_CATAGORY = 4,
  parameter int unsigned FRAME_BEATS  = 512,
  parameter int unsigned CNT_WIDTH    = $clog2(FRAME_BEATS)
) (
  input  logic                                               aclk,
  input  logic                                               aresetn,
  input  logic                                               start,
  input  logic                                               continuous,
  input  logic [(TAG_CATAGORY+1)*BEAT_SIZE*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TAG_CATAGORY:0]                              s_axis_tvalid,
  output logic [TAG_CATAGORY:0]                              s_axis_tready,
  input  logic [TAG_CATAGORY:0]                              s_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]                    m_axis_tdata,
  output logic                                               m_axis_tvalid,
  input  logic                                               m_axis_tready,
  output logic                                               m_axis_tlast,
  output logic                                               busy,
  output logic                                               done,
  output logic [TAG_CATAGORY:0]                              err_short,
  output logic [TAG_CATAGORY:0]                              err_long,
  output logic [15:0]                                        seq_cnt
);

  localparam int unsigned BEAT_WIDTH = BEAT_SIZE * DATA_WIDTH;
  localparam int unsigned NUM_SRC    = TAG_CATAGORY + 1;
  localparam int unsigned SEL_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_BEATS - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_SRC  = SEL_WIDTH'(TAG_CATAGORY);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t                 state;
  logic [SEL_WIDTH-1:0]   sel;
  logic [CNT_WIDTH-1:0]   beat_cnt;

  logic [BEAT_WIDTH-1:0]  src_data [NUM_SRC];
  logic                   sel_valid_c;
  logic                   sel_last_c;
  logic                   at_last_c;
  logic                   accept_c;
  logic                   frame_end_c;
  logic                   to_drain_c;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_data[gi] = s_axis_tdata[gi*BEAT_WIDTH +: BEAT_WIDTH];
  end

  // Zero-latency mux: the selected source talks straight to the assembler.
  always_comb begin
    sel_valid_c   = s_axis_tvalid[sel];
    sel_last_c    = s_axis_tlast[sel];
    at_last_c     = (beat_cnt == LAST_BEAT);
    m_axis_tdata  = src_data[sel];
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
      PASS: begin
        m_axis_tvalid      = sel_valid_c;
        m_axis_tlast       = sel_last_c | at_last_c;
        s_axis_tready[sel] = m_axis_tready;
      end
      DRAIN: s_axis_tready[sel] = 1'b1;
      default: ;
    endcase
    accept_c    = m_axis_tvalid & m_axis_tready;
    frame_end_c = ((state == PASS) & accept_c & sel_last_c) |
                  ((state == DRAIN) & sel_valid_c & sel_last_c);
    to_drain_c  = accept_c & at_last_c & ~sel_last_c;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      sel       <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      err_short <= '0;
      err_long  <= '0;
      seq_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PASS;
            sel       <= '0;
            beat_cnt  <= '0;
            err_short <= '0;
            err_long  <= '0;
          end
        end
        PASS, DRAIN: begin
          if (frame_end_c) begin
            beat_cnt <= '0;
            if (sel == LAST_SRC) begin
              done    <= 1'b1;
              seq_cnt <= seq_cnt + 16'd1;
              sel     <= '0;
              if (continuous) begin
                state     <= PASS;
                err_short <= '0;
                err_long  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sel   <= sel + SEL_WIDTH'(1);
              state <= PASS;
            end
            // Placed after the restart clear so a short final frame stays visible.
            if ((state == PASS) && !at_last_c) err_short[sel] <= 1'b1;
          end else if (to_drain_c) begin
            err_long[sel] <= 1'b1;
            state         <= DRAIN;
          end else if (accept_c) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_frame_sched.sv
// Directed bench for phase_frame_sched: table of per-source frame lengths plus
// hand-written continuous-mode and mid-frame reset sequences.
module tb_phase_frame_sched;

  localparam int unsigned DW = 16;
  localparam int unsigned BS = 8;
  localparam int unsigned TC = 4;
  localparam int unsigned FB = 4;
  localparam int unsigned NS = TC + 1;
  localparam int unsigned BW = DW * BS;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int unsigned   len [NS];
    logic [NS-1:0] exp_short;
    logic [NS-1:0] exp_long;
    bit            stall;
  } vec_t;

  logic              aclk;
  logic              aresetn;
  logic              start;
  logic              continuous;
  logic [NS*BW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tready;
  logic [NS-1:0]     s_axis_tlast;
  logic [BW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;
  logic [NS-1:0]     err_short;
  logic [NS-1:0]     err_long;
  logic [15:0]       seq_cnt;

  phase_frame_sched #(
    .DATA_WIDTH(DW), .BEAT_SIZE(BS), .TAG_CATAGORY(TC), .FRAME_BEATS(FB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .continuous(continuous),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .err_short(err_short), .err_long(err_long),
    .seq_cnt(seq_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  beat_t src_mem [NS][64];
  int    src_wr [NS];
  int    src_rd [NS];
  bit    presenting [NS];
  beat_t exp_mem [256];
  beat_t out_mem [256];
  int    exp_n, out_n;
  int    cyc, done_cnt, done_cyc, last_src_cyc, first_out_cyc, last_out_cyc;
  bit    stall_en, start_req, cont_lvl;
  int    n_vec, n_err, exp_seq;
  vec_t  vecs [5];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int v, input int s, input int b);
    return {32'(v), 32'(s), 32'(b), 32'hC0DE_0000 ^ 32'(s * 256 + b)};
  endfunction

  // Queue a frame at source s and append what the assembler should see from it.
  task automatic load_frame(input int v, input int s, input int len);
    int n;
    beat_t t;
    n = (len < int'(FB)) ? len : int'(FB);
    for (int b = 0; b < len; b++) begin
      t.data = mk(v, s, b);
      t.last = (b == len - 1);
      src_mem[s][src_wr[s]] = t;
      src_wr[s]++;
    end
    for (int b = 0; b < n; b++) begin
      t.data = mk(v, s, b);
      t.last = (b == n - 1);
      exp_mem[exp_n] = t;
      exp_n++;
    end
  endtask

  task automatic clear_bench();
    for (int i = 0; i < int'(NS); i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
      presenting[i] = 1'b0;
    end
    exp_n = 0; out_n = 0; done_cnt = 0;
    done_cyc = -1; last_src_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
  endtask

  // One clock: drive after the falling edge, observe handshakes just before the rising edge.
  task automatic cycle();
    @(negedge aclk);
    start = start_req;
    start_req = 1'b0;
    continuous = cont_lvl;
    m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < int'(NS); i++) begin
      if (!presenting[i] && src_rd[i] < src_wr[i] && (!stall_en || $urandom_range(0, 2) != 0))
        presenting[i] = 1'b1;
      s_axis_tvalid[i] = presenting[i];
      if (src_rd[i] < src_wr[i]) begin
        s_axis_tdata[i*BW +: BW] = src_mem[i][src_rd[i]].data;
        s_axis_tlast[i] = src_mem[i][src_rd[i]].last;
      end else begin
        s_axis_tdata[i*BW +: BW] = '0;
        s_axis_tlast[i] = 1'b0;
      end
    end
    #4;
    for (int i = 0; i < int'(NS); i++) begin
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        src_rd[i]++;
        presenting[i] = 1'b0;
        last_src_cyc = cyc;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (out_n < 256) out_mem[out_n] = {m_axis_tdata, m_axis_tlast};
      if (out_n == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_n++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      cycle();
      if (done_cnt >= target - 1) cont_lvl = 1'b0;
      k++;
    end
    chk("done_within_budget", BW'(done_cnt >= target), BW'(1));
    cycle();
    cycle();
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_beat_count"}, BW'(out_n), BW'(exp_n));
    for (int k = 0; k < exp_n && k < out_n && k < 256; k++) begin
      chk({tag, "_data"}, out_mem[k].data, exp_mem[k].data);
      chk({tag, "_tlast"}, BW'(out_mem[k].last), BW'(exp_mem[k].last));
    end
  endtask

  task automatic chk_consumed();
    for (int i = 0; i < int'(NS); i++)
      chk("src_consumed", BW'(src_rd[i]), BW'(src_wr[i]));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    clear_bench();
    stall_en = v.stall;
    for (int s = 0; s < int'(NS); s++) load_frame(id, s, int'(v.len[s]));
    start_req = 1'b1;
    run_until(1, 400);
    exp_seq++;
    compare_stream("vec");
    chk("err_short", BW'(err_short), BW'(v.exp_short));
    chk("err_long", BW'(err_long), BW'(v.exp_long));
    chk("seq_cnt", BW'(seq_cnt), BW'(exp_seq));
    chk("done_pulses", BW'(done_cnt), BW'(1));
    chk("done_latency", BW'(done_cyc), BW'(last_src_cyc + 1));
    chk("busy_after", BW'(busy), BW'(0));
    chk_consumed();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; exp_seq = 0; cyc = 0;
    stall_en = 1'b0; start_req = 1'b0; cont_lvl = 1'b0;
    clear_bench();
    vecs[0].len = '{4, 4, 4, 4, 4}; vecs[0].exp_short = 5'b00000; vecs[0].exp_long = 5'b00000; vecs[0].stall = 1'b0;
    vecs[1].len = '{4, 4, 2, 4, 4}; vecs[1].exp_short = 5'b00100; vecs[1].exp_long = 5'b00000; vecs[1].stall = 1'b0;
    vecs[2].len = '{4, 6, 4, 4, 4}; vecs[2].exp_short = 5'b00000; vecs[2].exp_long = 5'b00010; vecs[2].stall = 1'b0;
    vecs[3].len = '{4, 4, 4, 4, 4}; vecs[3].exp_short = 5'b00000; vecs[3].exp_long = 5'b00000; vecs[3].stall = 1'b1;
    vecs[4].len = '{1, 4, 4, 3, 5}; vecs[4].exp_short = 5'b01001; vecs[4].exp_long = 5'b10000; vecs[4].stall = 1'b1;

    // Reset state with every source presenting a last beat.
    aresetn = 1'b0; start = 1'b0; continuous = 1'b0; m_axis_tready = 1'b1;
    s_axis_tvalid = '1; s_axis_tlast = '1;
    for (int i = 0; i < int'(NS); i++) s_axis_tdata[i*BW +: BW] = mk(99, i, 7);
    #2;
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_done", BW'(done), BW'(0));
    chk("rst_m_tvalid", BW'(m_axis_tvalid), BW'(0));
    chk("rst_m_tlast", BW'(m_axis_tlast), BW'(0));
    chk("rst_s_tready", BW'(s_axis_tready), BW'(0));
    chk("rst_m_tdata", m_axis_tdata, mk(99, 0, 7));
    chk("rst_seq_cnt", BW'(seq_cnt), BW'(0));
    chk("rst_errs", BW'({err_short, err_long}), BW'(0));
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    s_axis_tvalid = '0;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v + 1);

    // Three back-to-back sequences in continuous mode.
    clear_bench();
    stall_en = 1'b0;
    for (int q = 0; q < 3; q++)
      for (int s = 0; s < int'(NS); s++) load_frame(10 + q, s, int'(FB));
    cont_lvl = 1'b1;
    start_req = 1'b1;
    run_until(3, 400);
    exp_seq += 3;
    compare_stream("cont");
    chk("cont_seq_cnt", BW'(seq_cnt), BW'(exp_seq));
    chk("cont_done_pulses", BW'(done_cnt), BW'(3));
    chk("cont_no_gap", BW'(last_out_cyc - first_out_cyc), BW'(3 * NS * FB - 1));
    chk("cont_errs", BW'({err_short, err_long}), BW'(0));
    chk("cont_busy_after", BW'(busy), BW'(0));

    // Reset in the middle of source 3's frame, then a clean sequence.
    clear_bench();
    for (int s = 0; s < int'(NS); s++) load_frame(20, s, int'(FB));
    start_req = 1'b1;
    for (int k = 0; k < 100 && out_n < 14; k++) cycle();
    chk("midframe_reached", BW'(out_n), BW'(14));
    chk("midframe_busy", BW'(busy), BW'(1));
    @(negedge aclk);
    aresetn = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast = '1;
    #1;
    exp_seq = 0;
    chk("mrst_busy", BW'(busy), BW'(0));
    chk("mrst_m_tvalid", BW'(m_axis_tvalid), BW'(0));
    chk("mrst_m_tlast", BW'(m_axis_tlast), BW'(0));
    chk("mrst_s_tready", BW'(s_axis_tready), BW'(0));
    chk("mrst_m_tdata", m_axis_tdata, s_axis_tdata[BW-1:0]);
    chk("mrst_seq_cnt", BW'(seq_cnt), BW'(0));
    chk("mrst_errs", BW'({err_short, err_long}), BW'(0));
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    run_vec(vecs[0], 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phase_frame_sched.md
# phase_frame_sched

Sequencer that feeds the phase-assembly datapath. It takes TAG_CATAGORY+1 independent AXI-Stream sources (phase maps 0..TAG_CATAGORY-1, then the tag map) and serialises one frame from each into a single stream in the fixed order the assembler expects. It enforces frame length, repairs bad tlast placement and reports status to the control/register layer. It sits directly upstream of the assembler's s_axis port.

## Interface
- DATA_WIDTH, 16, bits per sample
- BEAT_SIZE, 8, samples per beat; BEAT_WIDTH = BEAT_SIZE*DATA_WIDTH
- TAG_CATAGORY, 4, number of phase sources; source index TAG_CATAGORY is the tag map
- FRAME_BEATS, 512, expected beats per frame (≥2)
- CNT_WIDTH, $clog2(FRAME_BEATS), beat counter width
- aclk  in  1  clock
- aresetn  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; begins a map sequence when idle
- continuous  in  1  when 1, a new sequence starts automatically after each one completes
- s_axis_tdata  in  (TAG_CATAGORY+1)*BEAT_WIDTH  packed per-source data, source i at [i*BEAT_WIDTH +: BEAT_WIDTH]
- s_axis_tvalid  in  TAG_CATAGORY+1  per-source valid
- s_axis_tready  out  TAG_CATAGORY+1  per-source ready
- s_axis_tlast  in  TAG_CATAGORY+1  per-source end of frame
- m_axis_tdata  out  BEAT_WIDTH  to assembler
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence completes
- err_short  out  TAG_CATAGORY+1  sticky; source i ended early
- err_long  out  TAG_CATAGORY+1  sticky; source i exceeded FRAME_BEATS
- seq_cnt  out  16  completed sequences, wraps

## Operation
- States: IDLE, PASS, DRAIN. Registers: sel (source index), beat_cnt, error vectors, seq_cnt.
- IDLE: all s_axis_tready=0, m_axis_tvalid=0. start=1 → PASS, sel=0, beat_cnt=0, err_short/err_long cleared.
- PASS: source sel connected combinationally: m_tdata=s_tdata[sel], m_tvalid=s_tvalid[sel], s_tready[sel]=m_tready, other readies 0. Beat accepted when m_tvalid&m_tready.
- m_axis_tlast = s_tlast[sel] | (beat_cnt==FRAME_BEATS-1).
- Accepted beat, beat_cnt<FRAME_BEATS-1, s_tlast=0: beat_cnt+1.
- Accepted beat, beat_cnt<FRAME_BEATS-1, s_tlast=1: err_short[sel]=1, advance.
- Accepted beat, beat_cnt==FRAME_BEATS-1, s_tlast=1: normal end, advance.
- Accepted beat, beat_cnt==FRAME_BEATS-1, s_tlast=0: forced tlast downstream, err_long[sel]=1, → DRAIN.
- DRAIN: s_tready[sel]=1, m_tvalid=0; source beats discarded until a beat with s_tlast accepted, then advance.
- Advance: beat_cnt=0; if sel<TAG_CATAGORY, sel+1 and PASS; else sequence complete: done=1 for one cycle, seq_cnt+1, sel=0; continuous=1 → PASS (errors cleared), else → IDLE.
- busy=1 in PASS and DRAIN.
- start ignored while busy. start and completion in same cycle: continuous governs; start has no extra effect.
- Downstream always receives exactly FRAME_BEATS·(TAG_CATAGORY+1) beats per sequence except for short frames, each frame ending in exactly one tlast.

## Timing
- Zero-latency datapath: m_axis_* and s_axis_tready are combinational from sel/state and the selected inputs; no data register.
- Source switch takes effect the cycle after the final beat; no bubble beyond the handshake itself.
- done asserted the cycle after the final accepted beat (registered).
- Reset (async, any state, mid-frame included): state=IDLE, sel=0, beat_cnt=0, done=0, err_short=0, err_long=0, seq_cnt=0; hence busy=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata driven from source 0, m_axis_tlast=0 (beat_cnt=0, FRAME_BEATS≥2; source-0 tlast masked in IDLE). Partial frames are lost, not resumed.
- Error bits set on the cycle after the offending beat; held until next sequence start.
- m_tvalid must not drop without handshake is the source's obligation; the block adds no valid deassertion in PASS.

## Test plan
- FRAME_BEATS=4, TAG_CATAGORY=4, start, all sources supply 4-beat frames with tlast on beat 3, m_tready=1 → 20 beats out in order src0..src4, tlast on beats 3,7,11,15,19, done pulse one cycle after beat 19, seq_cnt=1, no errors.
- Source 2 sends tlast on beat 1 → downstream frame 2 is 2 beats with tlast, err_short=5'b00100, sequence still completes.
- Source 1 sends 6 beats, tlast on 5 → downstream beat 3 of frame 1 carries forced tlast, beats 4–5 dropped (tready=1, m_tvalid=0), err_long=5'b00010.
- Random m_tready (50%) and random source tvalid gaps → output data matches per-source reference queues; no beat duplicated or lost.
- continuous=1, three sequences → seq_cnt=3, three done pulses, no idle cycle between sequences beyond source stalls.
- aresetn asserted mid-frame of source 3 → outputs take reset values immediately; after release and start, sequence restarts at source 0 with beat_cnt=0.
